// File: rtl/std_rr_arbiter.sv
// -----------------------------------------------------------------------------
// std_rr_arbiter
//
// Round-robin arbiter that shares one downstream resource among N requesters.
// The grant is registered, one-hot, and held until the resource acknowledges
// completion. An acknowledge re-arbitrates on the same edge, so back-to-back
// grants come out with no idle cycle in between.
//
// Parameters
//   N   number of requesters, 1..32 (default 4)
//   IW  grant index width, derived: (N > 1) ? $clog2(N) : 1 (not overridable)
//
// Ports
//   i_clk        in   1   clock; all state changes on the rising edge
//   i_rst        in   1   asynchronous, active-high reset
//   i_req        in   N   request vector; bit k = requester k wants the resource
//   i_ack        in   1   resource finished the current transaction (used only
//                         while o_valid=1)
//   o_grant      out  N   registered one-hot grant; all-zero when idle
//   o_grant_idx  out  IW  binary index of the granted requester; 0 when idle
//   o_valid      out  1   a grant is active (taken from the state register)
//   o_err        out  1   sticky grant-integrity error
//
// Optional feature
//   Define STD_RR_ARBITER_ONEHOT_CHECK_EN to build a grant-integrity checker
//   around std_onehot. Without the macro o_err is tied low and no checker logic
//   exists; arbitration behaves identically in both builds.
// -----------------------------------------------------------------------------

`ifdef STD_RR_ARBITER_ONEHOT_CHECK_EN
// -----------------------------------------------------------------------------
// std_onehot
//
// Purely combinational classifier for a W-bit vector.
//
// Ports
//   vec     in   W   vector to classify
//   onehot  out  1   exactly one bit of vec is set
//   zero    out  1   no bit of vec is set
// -----------------------------------------------------------------------------
module std_onehot #(
   parameter int W = 4
) (
   input  logic [W-1:0] vec,
   output logic         onehot,
   output logic         zero
);

   assign zero   = (vec == '0);
   // Clearing the lowest set bit leaves zero only for a power of two.
   assign onehot = !zero && ((vec & (vec - W'(1))) == '0);

endmodule
`endif

module std_rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [N-1:0]  i_req,
   input  logic          i_ack,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_grant_idx,
   output logic          o_valid,
   output logic          o_err
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t         state_reg;
   logic [IW-1:0]  ptr_reg;
   logic [N-1:0]   grant_reg;
   logic [IW-1:0]  idx_reg;

   logic [N-1:0]   upper_mask;
   logic [N-1:0]   upper_req;
   logic [N-1:0]   win_onehot;
   logic [IW-1:0]  win_idx;
   logic [IW-1:0]  ptr_next;
   logic           win_found;
   logic           arb_point;

   // Index of the lowest set bit of v; 0 when v is empty.
   function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
      logic [IW-1:0] idx;
      idx = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (v[j]) begin
            idx = IW'(j);
         end
      end
      return idx;
   endfunction

   // Requests at or above the pointer take precedence. If none is set, the
   // search wraps to the lowest set bit of the whole vector, which is exactly
   // the first set bit scanning upward from ptr modulo N.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mask
         assign upper_mask[gi] = (IW'(gi) >= ptr_reg);
         assign win_onehot[gi] = (win_idx == IW'(gi));
      end
   endgenerate

   assign upper_req = i_req & upper_mask;
   assign win_found = |i_req;
   assign win_idx   = (|upper_req) ? lowest_set(upper_req) : lowest_set(i_req);

   // The winner becomes lowest priority for the next round. With N=1 the
   // winner is always N-1, so the pointer stays at 0.
   assign ptr_next  = (win_idx == IW'(N - 1)) ? '0 : (win_idx + IW'(1));

   // Re-arbitrate when idle, or on the acknowledge edge of a busy grant.
   assign arb_point = (state_reg == ST_IDLE) || i_ack;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
         grant_reg <= '0;
         idx_reg   <= '0;
      end else if (arb_point) begin
         if (win_found) begin
            state_reg <= ST_BUSY;
            grant_reg <= win_onehot;
            idx_reg   <= win_idx;
            ptr_reg   <= ptr_next;
         end else begin
            // Nobody asking: go idle and keep the pointer where it was.
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
         end
      end
      // Busy without an acknowledge: grant, index and pointer hold and
      // request changes are ignored.
   end

   assign o_grant     = grant_reg;
   assign o_grant_idx = idx_reg;
   assign o_valid     = (state_reg == ST_BUSY);

`ifdef STD_RR_ARBITER_ONEHOT_CHECK_EN
   logic          grant_onehot;
   logic          grant_zero;
   logic [N-1:0]  idx_hit;
   logic          idx_ok;
   logic          err_next;
   logic          err_reg;

   std_onehot #(
      .W (N)
   ) u_grant_check (
      .vec    (grant_reg),
      .onehot (grant_onehot),
      .zero   (grant_zero)
   );

   // The grant bit selected by the index must be set; built per bit so a
   // non-power-of-two N never indexes outside the grant vector.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_idx_hit
         assign idx_hit[gi] = grant_reg[gi] && (idx_reg == IW'(gi));
      end
   endgenerate

   assign idx_ok   = |idx_hit;
   assign err_next = (o_valid && !grant_onehot)
                   || (!o_valid && !grant_zero)
                   || (o_valid && !idx_ok);

   // Sticky: once an inconsistency is seen it stays flagged until reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_reg <= 1'b0;
      end else if (err_next) begin
         err_reg <= 1'b1;
      end
   end

   assign o_err = err_reg;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_std_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_std_rr_arbiter
//
// Bench for std_rr_arbiter: an N=4 instance driven with directed and random
// stimulus and compared against a behavioural round-robin model, plus an N=1
// instance for the single-requester re-grant case.
// -----------------------------------------------------------------------------
module tb_std_rr_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  req = '0;
   logic          ack = 1'b0;
   logic [N-1:0]  grant;
   logic [1:0]    grant_idx;
   logic          valid;
   logic          err;

   logic          req1 = 1'b0;
   logic          ack1 = 1'b0;
   logic [0:0]    grant1;
   logic [0:0]    grant_idx1;
   logic          valid1;
   logic          err1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Behavioural model: pointer, whether a grant is held, and who holds it.
   int m_ptr   = 0;
   bit m_valid = 1'b0;
   int m_idx   = 0;

   always #5 clk = ~clk;

   std_rr_arbiter #(.N(N)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_ack       (ack),
      .o_grant     (grant),
      .o_grant_idx (grant_idx),
      .o_valid     (valid),
      .o_err       (err)
   );

   std_rr_arbiter #(.N(1)) dut1 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req1),
      .i_ack       (ack1),
      .o_grant     (grant1),
      .o_grant_idx (grant_idx1),
      .o_valid     (valid1),
      .o_err       (err1)
   );

   function automatic logic [N-1:0] exp_grant();
      logic [N-1:0] g;
      g = '0;
      if (m_valid) g[m_idx] = 1'b1;
      return g;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 1'b0;
      m_idx   = 0;
   endtask

   // Apply the arbitration rules to the inputs present before the edge.
   task automatic model_edge();
      bit found;
      int w;
      if (!m_valid || ack) begin
         found = 1'b0;
         w     = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
               found = 1'b1;
               w     = (m_ptr + k) % N;
            end
         end
         if (found) begin
            m_valid = 1'b1;
            m_idx   = w;
            m_ptr   = (w + 1) % N;
         end else begin
            m_valid = 1'b0;
            m_idx   = 0;
         end
      end
   endtask

   // One clock: update the model, take the edge, settle 1 time unit after.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d req=%b ack=%b -> grant=%b idx=%0d valid=%b err=%b",
               cyc, req, ack, grant, grant_idx, valid, err);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      ack  = 1'b0;
      req1 = 1'b0;
      ack1 = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++;
      if (grant !== 4'b0000 || grant_idx !== 2'd0 || valid !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: grant=%b idx=%0d valid=%b err=%b required 0000/0/0/0",
                  grant, grant_idx, valid, err);
      end
      n_checks++;
      if (grant1 !== 1'b0 || valid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state_n1: grant=%b valid=%b required 0/0", grant1, valid1);
      end
      do_reset();
      // Get to a busy grant of 0100, then reset mid-transaction.
      req = 4'b0100;
      step();
      n_checks++;
      if (grant !== 4'b0100 || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_grant: grant=%b valid=%b required 0100/1", grant, valid);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (grant !== 4'b0000 || valid !== 1'b0 || err !== 1'b0 || grant_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid_busy: grant=%b idx=%0d valid=%b err=%b required 0000/0/0/0",
                  grant, grant_idx, valid, err);
      end
      rst = 1'b0;
      model_reset();
      req = 4'b0001;
      step();
      n_checks++;
      if (grant !== 4'b0001 || grant !== exp_grant() || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_grant: grant=%b valid=%b required 0001/1", grant, valid);
      end
   endtask

   task automatic test_rotation();
      logic [N-1:0] seq_g [5];
      int           seq_i [5];
      seq_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      seq_i = '{0, 1, 2, 3, 0};
      do_reset();
      req = 4'b1111;
      ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (grant !== seq_g[i] || grant_idx !== 2'(seq_i[i]) || valid !== 1'b1
             || grant !== exp_grant()) begin
            n_fail++;
            $display("FAIL rotation[%0d]: grant=%b idx=%0d valid=%b required %b/%0d/1",
                     i, grant, grant_idx, valid, seq_g[i], seq_i[i]);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      req = 4'b0010;
      step();
      ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req = (i % 2 == 0) ? 4'b1111 : 4'b0000;
         step();
         n_checks++;
         if (grant !== 4'b0010 || grant_idx !== 2'd1 || valid !== 1'b1
             || grant !== exp_grant()) begin
            n_fail++;
            $display("FAIL hold[%0d]: grant=%b idx=%0d valid=%b required 0010/1/1",
                     i, grant, grant_idx, valid);
         end
      end
      ack = 1'b1;
      req = 4'b0000;
      step();
      n_checks++;
      if (valid !== 1'b0 || grant !== 4'b0000 || grant_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL hold_release: grant=%b idx=%0d valid=%b required 0000/0/0",
                  grant, grant_idx, valid);
      end
      // Acknowledge while idle is ignored: still idle with no request.
      step();
      n_checks++;
      if (valid !== 1'b0 || grant !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_ack: grant=%b valid=%b required 0000/0", grant, valid);
      end
   endtask

   task automatic test_skip_wrap();
      do_reset();
      req = 4'b0100;
      step();
      // Holder 2, pointer now 3; request 0101 must wrap to requester 0.
      ack = 1'b1;
      req = 4'b0101;
      step();
      n_checks++;
      if (grant !== 4'b0001 || grant_idx !== 2'd0 || grant !== exp_grant()) begin
         n_fail++;
         $display("FAIL skip_wrap: grant=%b idx=%0d required 0001/0", grant, grant_idx);
      end
      step();
      n_checks++;
      if (grant !== 4'b0100 || grant_idx !== 2'd2 || grant !== exp_grant()) begin
         n_fail++;
         $display("FAIL skip_next: grant=%b idx=%0d required 0100/2", grant, grant_idx);
      end
   endtask

   task automatic test_sole_regrant();
      do_reset();
      req = 4'b0100;
      step();
      ack = 1'b1;
      step();
      n_checks++;
      if (grant !== 4'b0100 || valid !== 1'b1 || grant !== exp_grant()) begin
         n_fail++;
         $display("FAIL sole_regrant: grant=%b valid=%b required 0100/1", grant, valid);
      end
      // Holder 2 acks while 0 and 2 ask: 0 wins, 2 has lowest priority.
      req = 4'b0101;
      step();
      n_checks++;
      if (grant !== 4'b0001 || grant !== exp_grant()) begin
         n_fail++;
         $display("FAIL holder_lowest: grant=%b required 0001", grant);
      end
      req  = 4'b0000;
      ack  = 1'b0;
      req1 = 1'b1;
      ack1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (grant1 !== 1'b1 || grant_idx1 !== 1'b0 || valid1 !== 1'b1 || err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL n1_regrant[%0d]: grant=%b idx=%0d valid=%b err=%b required 1/0/1/0",
                     i, grant1, grant_idx1, valid1, err1);
         end
      end
      req1 = 1'b0;
      step();
      n_checks++;
      if (grant1 !== 1'b0 || valid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL n1_idle: grant=%b valid=%b required 0/0", grant1, valid1);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] g_exp;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         req = N'($urandom);
         ack = ($urandom_range(0, 3) != 0);
         step();
         g_exp = exp_grant();
         n_checks++;
         if (grant !== g_exp || grant_idx !== 2'(m_idx) || valid !== m_valid) begin
            n_fail++;
            $display("FAIL random[%0d]: grant=%b idx=%0d valid=%b required %b/%0d/%b",
                     i, grant, grant_idx, valid, g_exp, m_idx, m_valid);
         end
`ifndef STD_RR_ARBITER_ONEHOT_CHECK_EN
         n_checks++;
         if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL random_err[%0d]: err=%b required 0", i, err);
         end
`endif
      end
   endtask

   task automatic test_checker();
`ifdef STD_RR_ARBITER_ONEHOT_CHECK_EN
      do_reset();
      req = 4'b0010;
      step();
      ack = 1'b0;
      force dut.grant_reg = 4'b0110;
      @(posedge clk);
      #1;
      release dut.grant_reg;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL checker_sticky[%0d]: err=%b required 1", i, err);
         end
         @(posedge clk);
         #1;
      end
      do_reset();
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL checker_reset: err=%b required 0", err);
      end
`else
      n_checks++;
      if (err !== 1'b0 || err1 !== 1'b0) begin
         n_fail++;
         $display("FAIL checker_off: err=%b err1=%b required 0/0", err, err1);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_hold();
      test_skip_wrap();
      test_sole_regrant();
      test_random();
      test_checker();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
